// File: rtl/dma_avs_pkg.sv
// Shared definitions for the DMA Avalon-MM responder: FSM encoding,
// the value returned for reads of unmapped words, and parameter checks.
package dma_avs_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STALL  = 2'd1,
        ST_ACCEPT = 2'd2
    } resp_state_t;

    // Data returned for reads whose word index falls outside the RAM
    localparam logic [31:0] ERR_RDATA = 32'h0;

    localparam int MAX_WAIT_STATES  = 15;
    localparam int MIN_READ_LATENCY = 1;
    localparam int MAX_READ_LATENCY = 4;

    // DEPTH must be a power of two that still leaves at least one upper
    // address bit for out-of-range detection
    function automatic bit params_ok(input int depth, input int wait_states,
                                     input int read_latency);
        return (depth >= 2) && (depth <= (1 << 29)) && ((depth & (depth - 1)) == 0)
            && (wait_states >= 0) && (wait_states <= MAX_WAIT_STATES)
            && (read_latency >= MIN_READ_LATENCY) && (read_latency <= MAX_READ_LATENCY);
    endfunction

endpackage

// File: rtl/dma_resp_ram.sv
// Single-port word RAM with four byte-lane write enables and a
// registered read port (data appears the cycle after re is sampled).
module dma_resp_ram #(
    parameter  int DEPTH = 256,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [31:0]   wdata,
    input  logic          re,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    // Byte-lane write and registered read; contents are never reset
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dma_avs_responder.sv
// Avalon-MM responder in front of a word-addressed RAM. A small FSM
// inserts WAIT_STATES cycles of waitrequest before each command; reads
// come back through a fixed-length valid/data pipe of READ_LATENCY cycles.
module dma_avs_responder
    import dma_avs_pkg::*;
#(
    parameter int DEPTH        = 256,
    parameter int WAIT_STATES  = 0,
    parameter int READ_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] avs_s1_address,
    input  logic        avs_s1_read,
    input  logic        avs_s1_write,
    input  logic [31:0] avs_s1_writedata,
    input  logic [3:0]  avs_s1_byteenable,
    output logic        avs_s1_waitrequest,
    output logic        avs_s1_readdatavalid,
    output logic [31:0] avs_s1_readdata,
    output logic        err_sticky,
    input  logic        err_clr
);

    localparam int AW = $clog2(DEPTH);
    // The IDLE cycle that sees the request is itself the first wait state,
    // so STALL only has to cover WAIT_STATES-1 further cycles.
    localparam logic [3:0] STALL_INIT = (WAIT_STATES >= 2) ? 4'(WAIT_STATES - 2) : 4'd0;

    generate
        if (!params_ok(DEPTH, WAIT_STATES, READ_LATENCY)) begin : g_bad_params
            $error("dma_avs_responder: unsupported DEPTH/WAIT_STATES/READ_LATENCY");
        end
    endgenerate

    resp_state_t    state_reg;
    logic [3:0]     cnt_reg;
    logic           err_sticky_reg;
    logic           rd_v0_reg;
    logic           rd_oob0_reg;

    logic           req;
    logic           accept;
    logic           rd_accept;
    logic           addr_oob;
    logic           addr_misaligned;
    logic           cmd_err;
    logic           stall_drop;
    logic           ram_we;
    logic           ram_re;
    logic [AW-1:0]  word_idx;
    logic [31:0]    ram_rdata;

    logic           stage_valid [READ_LATENCY];
    logic [31:0]    stage_data  [READ_LATENCY];

    assign req             = avs_s1_read | avs_s1_write;
    assign word_idx        = avs_s1_address[AW+1:2];
    assign addr_oob        = |avs_s1_address[31:AW+2];
    assign addr_misaligned = |avs_s1_address[1:0];
    assign accept          = req & ~avs_s1_waitrequest;
    // A simultaneous read+write is treated as a write; the read is dropped
    assign rd_accept       = accept & avs_s1_read & ~avs_s1_write;
    assign ram_we          = accept & avs_s1_write & ~addr_oob;
    assign ram_re          = rd_accept & ~addr_oob;
    assign cmd_err         = accept & (addr_oob | addr_misaligned | (avs_s1_read & avs_s1_write));
    assign stall_drop      = (state_reg == ST_STALL) & ~req;

    // Waitrequest: held high in reset, otherwise decoded from the FSM state
    always_comb begin
        avs_s1_waitrequest = 1'b1;
        if (rst_n) begin
            case (state_reg)
                ST_IDLE:   avs_s1_waitrequest = req && (WAIT_STATES != 0);
                ST_STALL:  avs_s1_waitrequest = 1'b1;
                ST_ACCEPT: avs_s1_waitrequest = 1'b0;
                default:   avs_s1_waitrequest = 1'b1;
            endcase
        end
    end

    // Wait-state FSM: every command starts a fresh stall from IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (req && (WAIT_STATES != 0)) begin
                        if (WAIT_STATES == 1) begin
                            state_reg <= ST_ACCEPT;
                        end else begin
                            state_reg <= ST_STALL;
                            cnt_reg   <= STALL_INIT;
                        end
                    end
                end
                ST_STALL: begin
                    if (!req) begin
                        state_reg <= ST_IDLE;
                    end else if (cnt_reg == '0) begin
                        state_reg <= ST_ACCEPT;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                ST_ACCEPT: state_reg <= ST_IDLE;
                default:   state_reg <= ST_IDLE;
            endcase
        end
    end

    // Sticky error flag; a new error in the same cycle beats err_clr
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sticky_reg <= 1'b0;
        end else if (cmd_err || stall_drop) begin
            err_sticky_reg <= 1'b1;
        end else if (err_clr) begin
            err_sticky_reg <= 1'b0;
        end
    end

    assign err_sticky = err_sticky_reg;

    dma_resp_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .addr  (word_idx),
        .we    (ram_we),
        .be    (avs_s1_byteenable),
        .wdata (avs_s1_writedata),
        .re    (ram_re),
        .rdata (ram_rdata)
    );

    // First read stage runs alongside the RAM's own output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_v0_reg   <= 1'b0;
            rd_oob0_reg <= 1'b0;
        end else begin
            rd_v0_reg   <= rd_accept;
            rd_oob0_reg <= rd_accept & addr_oob;
        end
    end

    assign stage_valid[0] = rd_v0_reg;
    assign stage_data[0]  = rd_oob0_reg ? ERR_RDATA : ram_rdata;

    // Remaining READ_LATENCY-1 stages; the pipe never stalls
    generate
        for (genvar gi = 1; gi < READ_LATENCY; gi++) begin : g_pipe
            logic        v_reg;
            logic [31:0] d_reg;

            // Shift one stage; reset discards any read in flight
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_reg <= 1'b0;
                    d_reg <= '0;
                end else begin
                    v_reg <= stage_valid[gi-1];
                    d_reg <= stage_data[gi-1];
                end
            end

            assign stage_valid[gi] = v_reg;
            assign stage_data[gi]  = d_reg;
        end
    endgenerate

    assign avs_s1_readdatavalid = stage_valid[READ_LATENCY-1];
    assign avs_s1_readdata      = avs_s1_readdatavalid ? stage_data[READ_LATENCY-1] : '0;

endmodule

// File: tb/tb_dma_avs_responder.sv
// Bench for dma_avs_responder: two instances (no wait states / latency 2,
// three wait states / latency 1) driven by a directed vector table, short
// hand sequences and random traffic, checked against an array/queue model.
module tb_dma_avs_responder;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr  [2];
    logic        rd    [2];
    logic        wr    [2];
    logic [31:0] wdata [2];
    logic [3:0]  be    [2];
    logic        wreq  [2];
    logic        rvalid[2];
    logic [31:0] rdata [2];
    logic        err   [2];
    logic        eclr  [2];

    always #5 clk = ~clk;

    dma_avs_responder #(.DEPTH(DEPTH), .WAIT_STATES(0), .READ_LATENCY(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .avs_s1_address(addr[0]), .avs_s1_read(rd[0]), .avs_s1_write(wr[0]),
        .avs_s1_writedata(wdata[0]), .avs_s1_byteenable(be[0]),
        .avs_s1_waitrequest(wreq[0]), .avs_s1_readdatavalid(rvalid[0]),
        .avs_s1_readdata(rdata[0]), .err_sticky(err[0]), .err_clr(eclr[0])
    );

    dma_avs_responder #(.DEPTH(DEPTH), .WAIT_STATES(3), .READ_LATENCY(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .avs_s1_address(addr[1]), .avs_s1_read(rd[1]), .avs_s1_write(wr[1]),
        .avs_s1_writedata(wdata[1]), .avs_s1_byteenable(be[1]),
        .avs_s1_waitrequest(wreq[1]), .avs_s1_readdatavalid(rvalid[1]),
        .avs_s1_readdata(rdata[1]), .err_sticky(err[1]), .err_clr(eclr[1])
    );

    function automatic int waits_of(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    typedef struct {
        int          d;
        bit          r;
        bit          w;
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  be;
        bit          clr;
        logic [31:0] exp_rd;
        bit          exp_err;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    exp_t        exp_q [2][$];
    exp_t        mon_e;
    logic [31:0] mem_m [2][DEPTH];
    bit          err_m [2];
    vec_t        tab   [16];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Read-return monitor: each valid must match the oldest expected read,
    // arrive on its due cycle, and readdata must be zero otherwise
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rvalid[d] === 1'b1) begin
                if (exp_q[d].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid dut%0d actual=1 expected=0 (cycle %0d)", d, cyc);
                end else begin
                    mon_e = exp_q[d].pop_front();
                    chk($sformatf("valid_cycle_dut%0d", d), 32'(cyc), 32'(mon_e.due));
                    chk($sformatf("readdata_dut%0d", d), rdata[d], mon_e.data);
                    $display("dut%0d read return data=%h at cycle %0d", d, rdata[d], cyc);
                end
            end else begin
                chk($sformatf("idle_readdata_dut%0d", d), rdata[d], 32'h0);
                if (exp_q[d].size() != 0 && exp_q[d][0].due <= cyc) begin
                    mon_e = exp_q[d].pop_front();
                    checks++;
                    errors++;
                    $display("FAIL missing_valid dut%0d actual=0 expected=1 due cycle %0d", d, mon_e.due);
                end
            end
        end
    end

    task automatic idle_all();
        for (int d = 0; d < 2; d++) begin
            rd[d] = 1'b0;
            wr[d] = 1'b0;
        end
    endtask

    // One bus command on dut d; entered and left #1 after a rising edge.
    // Command signals stay asserted on exit so the next call can follow back-to-back.
    task automatic cmd(input int d, input bit r, input bit w, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] b,
                       input bit use_tab, input logic [31:0] tab_data);
        int          stalls = 0;
        bit          got = 0;
        bit          oob;
        bit          bad;
        logic [7:0]  idx;
        logic [31:0] expd;
        rd[1-d] = 1'b0;
        wr[1-d] = 1'b0;
        rd[d] = r; wr[d] = w; addr[d] = a; wdata[d] = wd; be[d] = b;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (wreq[d] === 1'b0) begin
                got = 1;
                break;
            end
            stalls++;
            @(posedge clk);
            #1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout dut%0d actual=no_accept expected=accept", d);
        end
        chk($sformatf("stall_cycles_dut%0d", d), 32'(stalls), 32'(waits_of(d)));
        idx  = a[9:2];
        oob  = (a[31:10] != 22'h0);
        bad  = oob || (a[1:0] != 2'b00) || (r && w);
        if (bad) err_m[d] = 1'b1;
        if (w && !oob) begin
            for (int i = 0; i < 4; i++) begin
                if (b[i]) mem_m[d][idx][8*i +: 8] = wd[8*i +: 8];
            end
        end
        if (r && !w) begin
            expd = oob ? 32'h0 : mem_m[d][idx];
            if (use_tab) expd = tab_data;
            exp_q[d].push_back('{data: expd, due: cyc + lat_of(d)});
        end
        @(posedge clk);
        #1;
        chk($sformatf("err_sticky_dut%0d", d), 32'(err[d]), 32'(err_m[d]));
        $display("dut%0d cmd r=%0d w=%0d addr=%h wdata=%h be=%h stalls=%0d err=%0d",
                 d, r, w, a, wd, b, stalls, err[d]);
    endtask

    task automatic clear_err(input int d);
        idle_all();
        eclr[d] = 1'b1;
        @(posedge clk);
        #1;
        eclr[d] = 1'b0;
        err_m[d] = 1'b0;
        chk($sformatf("err_clr_dut%0d", d), 32'(err[d]), 32'(err_m[d]));
        $display("dut%0d err_clr err=%0d", d, err[d]);
    endtask

    task automatic reset_checks();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_waitrequest_dut%0d", d), 32'(wreq[d]), 32'h1);
            chk($sformatf("rst_readdatavalid_dut%0d", d), 32'(rvalid[d]), 32'h0);
            chk($sformatf("rst_readdata_dut%0d", d), rdata[d], 32'h0);
            chk($sformatf("rst_err_dut%0d", d), 32'(err[d]), 32'h0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          d;
        int          kind;
        bit          r;
        bit          w;
        logic [31:0] a;
        logic [7:0]  idx;

        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            addr[i] = '0; rd[i] = 0; wr[i] = 0; wdata[i] = '0; be[i] = '0; eclr[i] = 0;
            err_m[i] = 0;
        end

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_checks();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // d, r, w, addr, wdata, be, clear-first, expected read data, expected err
        tab[0]  = '{0, 0, 1, 32'h100, 32'hA5A5_1234, 4'hF, 0, 32'h0,         0};
        tab[1]  = '{0, 1, 0, 32'h100, 32'h0,         4'hF, 0, 32'hA5A5_1234, 0};
        tab[2]  = '{0, 0, 1, 32'h020, 32'h0,         4'hF, 0, 32'h0,         0};
        tab[3]  = '{0, 0, 1, 32'h020, 32'hFFFF_FFFF, 4'h5, 0, 32'h0,         0};
        tab[4]  = '{0, 1, 0, 32'h020, 32'h0,         4'h0, 0, 32'h00FF_00FF, 0};
        tab[5]  = '{0, 0, 1, 32'h3FC, 32'h7777_8888, 4'hF, 0, 32'h0,         0};
        tab[6]  = '{0, 1, 0, 32'h3FC, 32'h0,         4'hF, 0, 32'h7777_8888, 0};
        tab[7]  = '{0, 1, 0, 32'h400, 32'h0,         4'hF, 0, 32'h0,         1};
        tab[8]  = '{0, 1, 0, 32'h101, 32'h0,         4'hF, 1, 32'hA5A5_1234, 1};
        tab[9]  = '{0, 1, 1, 32'h024, 32'h55AA_55AA, 4'hF, 1, 32'h0,         1};
        tab[10] = '{0, 1, 0, 32'h024, 32'h0,         4'hF, 1, 32'h55AA_55AA, 0};
        tab[11] = '{1, 0, 1, 32'h040, 32'hCAFE_F00D, 4'hF, 0, 32'h0,         0};
        tab[12] = '{1, 1, 0, 32'h040, 32'h0,         4'hF, 0, 32'hCAFE_F00D, 0};
        tab[13] = '{1, 0, 1, 32'h000, 32'h1111_1111, 4'hF, 0, 32'h0,         0};
        tab[14] = '{1, 0, 1, 32'h400, 32'hDEAD_BEEF, 4'hF, 0, 32'h0,         1};
        tab[15] = '{1, 1, 0, 32'h000, 32'h0,         4'hF, 1, 32'h1111_1111, 0};

        for (int i = 0; i < 16; i++) begin
            if (tab[i].clr) clear_err(tab[i].d);
            cmd(tab[i].d, tab[i].r, tab[i].w, tab[i].a, tab[i].wd, tab[i].be, 1, tab[i].exp_rd);
            chk($sformatf("vec%0d_err", i), 32'(err[tab[i].d]), 32'(tab[i].exp_err));
            idle_all();
            repeat (3) @(posedge clk);
            #1;
        end
        clear_err(0);
        clear_err(1);

        // Fill both RAMs so every later read has a known model value
        for (int dd = 0; dd < 2; dd++) begin
            for (int wi = 0; wi < DEPTH; wi++) begin
                cmd(dd, 0, 1, {22'h0, 8'(wi), 2'b00}, $urandom, 4'hF, 0, 32'h0);
            end
            idle_all();
        end

        // Back-to-back writes then four back-to-back reads on the zero-wait port
        for (int wi = 0; wi < 4; wi++) cmd(0, 0, 1, {22'h0, 8'(wi), 2'b00}, $urandom, 4'hF, 0, 32'h0);
        for (int wi = 0; wi < 4; wi++) cmd(0, 1, 0, {22'h0, 8'(wi), 2'b00}, 32'h0, 4'hF, 0, 32'h0);
        idle_all();
        repeat (4) @(posedge clk);
        #1;

        // Read issued the cycle right after a write to the same word
        cmd(0, 0, 1, 32'h14, 32'h0BAD_CAFE, 4'hF, 0, 32'h0);
        cmd(0, 1, 0, 32'h14, 32'h0, 4'hF, 1, 32'h0BAD_CAFE);
        cmd(1, 0, 1, 32'h18, 32'h1357_9BDF, 4'hF, 0, 32'h0);
        cmd(1, 1, 0, 32'h18, 32'h0, 4'hF, 1, 32'h1357_9BDF);
        idle_all();
        repeat (4) @(posedge clk);
        #1;

        // Random traffic
        for (int n = 0; n < 300; n++) begin
            d    = int'($urandom_range(0, 1));
            kind = int'($urandom_range(0, 15));
            idx  = 8'($urandom_range(0, DEPTH - 1));
            a    = {22'h0, idx, 2'b00};
            r    = (kind >= 6 && kind <= 13) || kind == 15;
            w    = (kind < 6) || kind == 12 || kind == 14;
            if (kind == 13 || kind == 14) a[31:10] = 22'($urandom_range(1, 22'h3F_FFFF));
            if (kind == 15) a[1:0] = 2'($urandom_range(1, 3));
            cmd(d, r, w, a, $urandom, 4'($urandom_range(0, 15)), 0, 32'h0);
            if ($urandom_range(0, 2) == 0) begin
                idle_all();
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            if ($urandom_range(0, 14) == 0) clear_err(d);
        end
        idle_all();
        repeat (6) @(posedge clk);
        #1;

        // Reset asserted in the cycle after a read is accepted: the read is lost
        cmd(0, 1, 0, 32'h100, 32'h0, 4'hF, 0, 32'h0);
        idle_all();
        rst_n = 1'b0;
        exp_q[0].delete();
        err_m[0] = 1'b0;
        err_m[1] = 1'b0;
        @(negedge clk);
        reset_checks();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        $display("reset pulse applied with a read in flight");
        repeat (6) @(posedge clk);
        #1;

        for (int dd = 0; dd < 2; dd++) begin
            chk($sformatf("drain_empty_dut%0d", dd), 32'(exp_q[dd].size()), 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
